// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared state type and constants for the I2S receiver
package i2s_pkg;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_LEFT  = 2'd1,
    RX_RIGHT = 2'd2
  } i2s_rx_state_t;

  localparam logic WS_LEFT = 1'b0;

endpackage

// File: rtl/i2s_in_sync.sv
// rtl/i2s_in_sync.sv - synchroniser for BCK/WS/DIN with registered, aligned bck_rise
module i2s_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk32,
  input  logic reset,
  input  logic bck_i,
  input  logic ws_i,
  input  logic din_i,
  output logic bck_rise_o,
  output logic ws_o,
  output logic din_o
);

  logic [SYNC_STAGES-1:0] bck_sync_q;
  logic [SYNC_STAGES-1:0] ws_sync_q;
  logic [SYNC_STAGES-1:0] din_sync_q;
  logic                   bck_last_q;
  logic                   bck_rise_q;
  logic                   ws_q;
  logic                   din_q;

  // Shift each asynchronous input through its own synchroniser chain
  always_ff @(posedge clk32) begin
    if (reset) begin
      bck_sync_q <= '0;
      ws_sync_q  <= '0;
      din_sync_q <= '0;
    end else begin
      bck_sync_q <= {bck_sync_q[SYNC_STAGES-2:0], bck_i};
      ws_sync_q  <= {ws_sync_q[SYNC_STAGES-2:0], ws_i};
      din_sync_q <= {din_sync_q[SYNC_STAGES-2:0], din_i};
    end
  end

  // Register the rise detect with ws/din taken from the same stage so all three line up
  always_ff @(posedge clk32) begin
    if (reset) begin
      bck_last_q <= 1'b0;
      bck_rise_q <= 1'b0;
      ws_q       <= 1'b0;
      din_q      <= 1'b0;
    end else begin
      bck_last_q <= bck_sync_q[SYNC_STAGES-1];
      bck_rise_q <= bck_sync_q[SYNC_STAGES-1] & ~bck_last_q;
      ws_q       <= ws_sync_q[SYNC_STAGES-1];
      din_q      <= din_sync_q[SYNC_STAGES-1];
    end
  end

  assign bck_rise_o = bck_rise_q;
  assign ws_o       = ws_q;
  assign din_o      = din_q;

endmodule

// File: rtl/i2s_rx.sv
// rtl/i2s_rx.sv - I2S receiver top: framing FSM, shifter, staging and outputs (I2S_RX_PHILIPS_EN selects Philips framing)
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int SLOT_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk32,
  input  logic              reset,
  input  logic              i2s_bck,
  input  logic              i2s_ws,
  input  logic              i2s_din,
  output logic [DATA_W-1:0] audio_l,
  output logic [DATA_W-1:0] audio_r,
  output logic              sample_valid,
  output logic              locked,
  output logic              frame_err
);

  localparam int              CNT_W    = $clog2(SLOT_W + 2);
  localparam logic [CNT_W-1:0] SLOT_CNT = CNT_W'(SLOT_W);
  localparam logic [CNT_W-1:0] DATA_CNT = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] SAT_CNT  = CNT_W'(SLOT_W + 1);

  logic bit_rise;
  logic ws_s;
  logic din_s;
  logic ws_edge;
  logic slot_end;
  logic slot_ws;

  i2s_rx_state_t     state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] stage_q, stage_d;
  logic [DATA_W-1:0] audio_l_q, audio_l_d;
  logic [DATA_W-1:0] audio_r_q, audio_r_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic              locked_q, locked_d;
  logic              ws_prev_q, ws_prev_d;

  i2s_in_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk32     (clk32),
    .reset     (reset),
    .bck_i     (i2s_bck),
    .ws_i      (i2s_ws),
    .din_i     (i2s_din),
    .bck_rise_o(bit_rise),
    .ws_o      (ws_s),
    .din_o     (din_s)
  );

  assign ws_edge = bit_rise && (ws_s != ws_prev_q);

`ifdef I2S_RX_PHILIPS_EN
  logic edge_pend_q;
  logic edge_ws_q;

  // Remember a WS edge so the slot closes one bck_rise later, after the old slot's LSB
  always_ff @(posedge clk32) begin
    if (reset) begin
      edge_pend_q <= 1'b0;
      edge_ws_q   <= 1'b0;
    end else if (bit_rise) begin
      edge_pend_q <= ws_edge;
      edge_ws_q   <= ws_s;
    end
  end

  assign slot_end = bit_rise && edge_pend_q;
  assign slot_ws  = edge_ws_q;
`else
  assign slot_end = ws_edge;
  assign slot_ws  = ws_s;
`endif

  // Next-state: slot close/open on slot_end, otherwise shift and count the current slot
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    stage_d   = stage_q;
    audio_l_d = audio_l_q;
    audio_r_d = audio_r_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    locked_d  = locked_q;
    ws_prev_d = ws_prev_q;
    if (bit_rise) begin
      ws_prev_d = ws_s;
      if (slot_end) begin
        if (state_q == RX_IDLE) begin
          if (slot_ws == WS_LEFT) begin
            state_d   = RX_LEFT;
            shreg_d   = {{(DATA_W-1){1'b0}}, din_s};
            bit_cnt_d = CNT_W'(1);
          end
        end else if (bit_cnt_q == SLOT_CNT) begin
          if (state_q == RX_LEFT) begin
            stage_d = shreg_q;
            state_d = RX_RIGHT;
          end else begin
            audio_l_d = stage_q;
            audio_r_d = shreg_q;
            valid_d   = 1'b1;
            locked_d  = 1'b1;
            state_d   = RX_LEFT;
          end
          // The bit on this rise is already bit 0 of the new slot
          shreg_d   = {{(DATA_W-1){1'b0}}, din_s};
          bit_cnt_d = CNT_W'(1);
        end else begin
          err_d    = 1'b1;
          locked_d = 1'b0;
          state_d  = RX_IDLE;
        end
      end else if (state_q != RX_IDLE) begin
        if (bit_cnt_q < DATA_CNT) begin
          shreg_d = {shreg_q[DATA_W-2:0], din_s};
        end
        if (bit_cnt_q != SAT_CNT) begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk32) begin
    if (reset) begin
      state_q   <= RX_IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      stage_q   <= '0;
      audio_l_q <= '0;
      audio_r_q <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      locked_q  <= 1'b0;
      ws_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      stage_q   <= stage_d;
      audio_l_q <= audio_l_d;
      audio_r_q <= audio_r_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      locked_q  <= locked_d;
      ws_prev_q <= ws_prev_d;
    end
  end

  assign audio_l      = audio_l_q;
  assign audio_r      = audio_r_q;
  assign sample_valid = valid_q;
  assign locked       = locked_q;
  assign frame_err    = err_q;

endmodule

// File: tb/tb_i2s_rx.sv
// tb/tb_i2s_rx.sv - randomized self-checking bench for i2s_rx against a slot-level reference model
module tb_i2s_rx;

  localparam int DATA_W = 16;
  localparam int SLOT_W = 16;

  logic              clk32 = 1'b0;
  logic              reset = 1'b1;
  logic              bck   = 1'b0;
  logic              ws    = 1'b0;
  logic              din   = 1'b0;
  logic [DATA_W-1:0] audio_l;
  logic [DATA_W-1:0] audio_r;
  logic              sample_valid;
  logic              locked;
  logic              frame_err;

  int tests = 0;
  int fails = 0;

  logic ws_a  [0:4095];
  logic din_a [0:4095];
  int   n_bits;

  logic [31:0] mon_q[$];
  int          mon_err;
  logic [31:0] exp_q[$];
  int          exp_err;
  logic        exp_locked;
  logic [15:0] exp_l;
  logic [15:0] exp_r;

  i2s_rx #(.DATA_W(DATA_W), .SLOT_W(SLOT_W), .SYNC_STAGES(2)) dut (
    .clk32       (clk32),
    .reset       (reset),
    .i2s_bck     (bck),
    .i2s_ws      (ws),
    .i2s_din     (din),
    .audio_l     (audio_l),
    .audio_r     (audio_r),
    .sample_valid(sample_valid),
    .locked      (locked),
    .frame_err   (frame_err)
  );

  always #5 clk32 = ~clk32;

  // Collect output pulses away from the active edge
  always @(negedge clk32) begin
    if (!reset) begin
      if (sample_valid) mon_q.push_back({audio_l, audio_r});
      if (frame_err) mon_err++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic new_stream();
    n_bits = 0;
  endtask

  task automatic add_bits(input logic w, input int cnt);
    for (int j = 0; j < cnt; j++) begin
      ws_a[n_bits]  = w;
      din_a[n_bits] = 1'($urandom_range(1, 0));
      n_bits++;
    end
  endtask

  task automatic add_slot(input logic w, input logic [15:0] val, input int len);
    for (int j = 0; j < len; j++) begin
      ws_a[n_bits]  = w;
      din_a[n_bits] = (j < 16) ? val[15-j] : 1'($urandom_range(1, 0));
      n_bits++;
    end
  endtask

  task automatic add_frame(input logic [15:0] l, input logic [15:0] r);
    add_slot(1'b0, l, SLOT_W);
    add_slot(1'b1, r, SLOT_W);
  endtask

  // WS moves one BCK ahead of the data, as a Philips transmitter sends it
  task automatic lead_shift();
    for (int i = 0; i < n_bits - 1; i++) ws_a[i] = ws_a[i+1];
  endtask

  task automatic finish_stream();
`ifdef I2S_RX_PHILIPS_EN
    lead_shift();
`endif
  endtask

  task automatic drive_range(input int from, input int to, input int half);
    for (int i = from; i < to; i++) begin
      @(negedge clk32);
      bck = 1'b0;
      ws  = ws_a[i];
      din = din_a[i];
      repeat (half) @(negedge clk32);
      bck = 1'b1;
      repeat (half - 1) @(negedge clk32);
    end
  endtask

  task automatic clear_mon();
    mon_q.delete();
    mon_err = 0;
  endtask

  task automatic do_reset();
    @(negedge clk32);
    reset = 1'b1;
    bck   = 1'b0;
    ws    = 1'b0;
    din   = 1'b0;
    repeat (3) @(negedge clk32);
    reset = 1'b0;
    clear_mon();
  endtask

  function automatic logic [15:0] slot_value(input int s);
    logic [15:0] v;
    for (int j = 0; j < 16; j++) v[15-j] = din_a[s+j];
    return v;
  endfunction

  // Slot-level model: find WS runs (the receiver's view of WS), judge each closed run by length
  task automatic run_model(input int start);
    int          st;
    int          seg_s;
    logic        prev;
    logic        w;
    logic [15:0] stage;
    logic [15:0] v;
    exp_q.delete();
    exp_err    = 0;
    exp_locked = 1'b0;
    exp_l      = '0;
    exp_r      = '0;
    stage      = '0;
    st         = 0;
    prev       = 1'b0;
    seg_s      = start;
    for (int i = start; i < n_bits; i++) begin
`ifdef I2S_RX_PHILIPS_EN
      w = (i == start) ? 1'b0 : ws_a[i-1];
`else
      w = ws_a[i];
`endif
      if (w != prev) begin
        if (st != 0) begin
          if (i - seg_s == SLOT_W) begin
            v = slot_value(seg_s);
            if (st == 1) begin
              stage = v;
              st    = 2;
            end else begin
              exp_q.push_back({stage, v});
              exp_l      = stage;
              exp_r      = v;
              exp_locked = 1'b1;
              st         = 1;
            end
          end else begin
            exp_err++;
            exp_locked = 1'b0;
            st         = 0;
          end
        end else if (w == 1'b0) begin
          st = 1;
        end
        seg_s = i;
        prev  = w;
      end
    end
  endtask

  task automatic compare_run(input string name);
    check_eq({name, "_npulse"}, mon_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++)
      check_eq({name, "_pair"}, mon_q[i], exp_q[i]);
    check_eq({name, "_err"}, mon_err, exp_err);
    check_eq({name, "_locked"}, {31'd0, locked}, {31'd0, exp_locked});
    check_eq({name, "_audio_l"}, {16'd0, audio_l}, {16'd0, exp_l});
    check_eq({name, "_audio_r"}, {16'd0, audio_r}, {16'd0, exp_r});
  endtask

  task automatic play(input string name, input int half);
    drive_range(0, n_bits, half);
    repeat (30) @(negedge clk32);
    run_model(0);
    compare_run(name);
  endtask

  int rst_at;

  initial begin
    // Reset state
    do_reset();
    check_eq("rst_audio_l", {16'd0, audio_l}, 32'd0);
    check_eq("rst_audio_r", {16'd0, audio_r}, 32'd0);
    check_eq("rst_valid", {31'd0, sample_valid}, 32'd0);
    check_eq("rst_locked", {31'd0, locked}, 32'd0);
    check_eq("rst_err", {31'd0, frame_err}, 32'd0);

    // 1: four frames of 1234/ABCD at BCK = clk32/40
    new_stream();
    add_bits(1'b1, 2);
    for (int f = 0; f < 4; f++) add_frame(16'h1234, 16'hABCD);
    add_bits(1'b0, 2);
    finish_stream();
    play("t1", 20);
    check_eq("t1_count", mon_q.size(), 32'd4);
    for (int i = 0; i < mon_q.size(); i++) check_eq("t1_value", mon_q[i], 32'h1234ABCD);

    // 2: extreme values alternating
    do_reset();
    new_stream();
    add_bits(1'b1, 2);
    for (int f = 0; f < 3; f++) begin
      add_frame(16'h8000, 16'h7FFF);
      add_frame(16'h0000, 16'hFFFF);
    end
    add_bits(1'b0, 2);
    finish_stream();
    play("t2", 4);

    // 3: one 15-bit right slot mid-stream
    do_reset();
    new_stream();
    add_bits(1'b1, 2);
    add_frame(16'h1111, 16'h2222);
    add_frame(16'h3333, 16'h4444);
    add_slot(1'b0, 16'h5555, 16);
    add_slot(1'b1, 16'h6666, 15);
    add_frame(16'h7777, 16'h8888);
    add_frame(16'h9999, 16'hAAAA);
    add_frame(16'hBBBB, 16'hCCCC);
    add_bits(1'b0, 2);
    finish_stream();
    play("t3", 4);

    // 4: WS stuck low for 100 BCK
    do_reset();
    new_stream();
    add_bits(1'b1, 2);
    add_frame(16'hCAFE, 16'hBEEF);
    add_slot(1'b0, 16'h0F0F, 100);
    add_slot(1'b1, 16'hF0F0, 16);
    add_frame(16'h1357, 16'h2468);
    add_frame(16'h0246, 16'h1359);
    add_bits(1'b0, 2);
    finish_stream();
    play("t4", 4);
    check_eq("t4_err_seen", {31'd0, (mon_err > 0)}, 32'd1);

    // 5: reset mid right slot
    do_reset();
    new_stream();
    add_bits(1'b1, 2);
    add_frame(16'hA5A5, 16'h5A5A);
    add_frame(16'h1234, 16'h4321);
    add_slot(1'b0, 16'hDEAD, 16);
    rst_at = n_bits + 8;
    add_slot(1'b1, 16'hFACE, 16);
    add_frame(16'h0102, 16'h0304);
    add_frame(16'h0506, 16'h0708);
    add_bits(1'b0, 2);
    finish_stream();
    drive_range(0, rst_at, 4);
    @(negedge clk32);
    reset = 1'b1;
    bck   = 1'b0;
    @(negedge clk32);
    reset = 1'b0;
    check_eq("t5_rst_l", {16'd0, audio_l}, 32'd0);
    check_eq("t5_rst_r", {16'd0, audio_r}, 32'd0);
    check_eq("t5_rst_locked", {31'd0, locked}, 32'd0);
    check_eq("t5_rst_valid", {31'd0, sample_valid}, 32'd0);
    clear_mon();
    repeat (4) @(negedge clk32);
    drive_range(rst_at, n_bits, 4);
    repeat (30) @(negedge clk32);
    run_model(rst_at);
    compare_run("t5");

    // 6: stream with WS one BCK ahead of the data
    do_reset();
    new_stream();
    add_bits(1'b1, 2);
    for (int f = 0; f < 4; f++) add_frame(16'h1234, 16'hABCD);
    add_bits(1'b0, 2);
    lead_shift();
    play("t6", 4);
    check_eq("t6_no_err", mon_err, 32'd0);
`ifdef I2S_RX_PHILIPS_EN
    check_eq("t6_count", mon_q.size(), 32'd4);
    for (int i = 0; i < mon_q.size(); i++) check_eq("t6_value", mon_q[i], 32'h1234ABCD);
`endif

    // 7: random data, random glitch slot lengths, random BCK rate
    for (int r = 0; r < 3; r++) begin
      do_reset();
      new_stream();
      add_bits(1'b1, $urandom_range(3, 1));
      for (int f = 0; f < 6; f++) begin
        add_slot(1'b0, 16'($urandom), ($urandom_range(5, 0) == 0) ? $urandom_range(17, 15) : 16);
        add_slot(1'b1, 16'($urandom), ($urandom_range(5, 0) == 0) ? $urandom_range(17, 15) : 16);
      end
      add_bits(1'b0, 2);
      finish_stream();
      play("t7", $urandom_range(6, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls
  initial begin
    #5000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
